lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
Load/store initiator that drives the single-port data memory interface (address, write_data, write_enable, read_data) on behalf of the DSP pipeline. Accepts byte, halfword and word requests over a valid/ready handshake. Sub-word stores are performed as read-modify-write. Load results are lane-extracted, extended, and returned over a valid/ready response channel.

Parameters:
ADDR_W, 32, byte-address width of req_addr; mem_address is also ADDR_W wide
RD_LAT, 1, cycles mem_address is held before mem_read_data is sampled (legal range 1..4)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  in  1  sign-extend load result (byte/half only)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_rdata  out  32  load result; 0 for stores
rsp_err  out  1  request rejected, no memory access made
mem_address  out  ADDR_W  word index = req_addr >> 2
mem_write_data  out  32  word to write
mem_write_enable  out  1  single-cycle write strobe
mem_read_data  in  32  memory read word
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_address=0; mem_write_data=0; mem_write_enable=0; busy=0; RD_LAT counter=0.
- Any in-flight request is discarded on reset; no response is produced and no write occurs.
- FSM states: IDLE, RD_WAIT, WR, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch we/size/signed/addr/wdata and drive mem_address=addr>>2 from the next cycle.
  - Word store -> WR.
  - Load or sub-word store -> RD_WAIT.
  - Error request -> RESP.
- RD_WAIT: hold mem_address for RD_LAT cycles, then sample mem_read_data at the end of the last cycle.
  - Load -> RESP with extracted data.
  - Sub-word store -> WR with merged word.
- WR: mem_write_enable=1 for exactly one cycle; mem_address and mem_write_data are stable during that cycle -> RESP.
- RESP: rsp_valid=1, with rsp_rdata and rsp_err held stable until rsp_ready. On the handshake, go to IDLE.
- req_ready=0 in every state except IDLE; there is no overlap of requests.
- Lane mapping is little-endian:
  - Byte lane = addr[1:0], bits [8k+7:8k].
  - Half lane = addr[1], bits [16h+15:16h].
- Load extension: req_signed=1 sign-extends to 32 bits; req_signed=0 zero-extends. Word loads ignore req_signed.
- Store merge: only the addressed lane is replaced with req_wdata[7:0] or [15:0]; all other bytes keep the read value.
- Latency, with accept in cycle N:
  - Word store: write_enable in N+1, rsp_valid in N+2.
  - Load: rsp_valid in N+RD_LAT+1.
  - Sub-word store: write in N+RD_LAT+1, rsp_valid in N+RD_LAT+2.
- mem_address and mem_write_data hold their last values in IDLE. mem_write_enable is never high outside WR.
- req_size=11 always gives rsp_err=1, rsp_rdata=0, and no memory access.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, makes no memory access. The block goes straight to RESP with rsp_err=1 and rsp_rdata=0.
- Undefined: misaligned low address bits are ignored. Half uses lane addr[1]; word uses index addr>>2. rsp_err is asserted only for req_size=11.

Test Plan:
1. Word store 0xA5A5A5A5 to addr 0x0 -> one mem_write_enable pulse in N+1 with mem_address=0 and mem_write_data=0xA5A5A5A5; rsp_valid in N+2 with rsp_err=0.
2. Signed byte load from addr 0x6, memory index 1 = 0x12845678, RD_LAT=1 -> rsp_rdata=0xFFFFFF84. The same load unsigned -> 0x00000084.
3. Half store 0xBEEF to addr 0x16, memory index 5 = 0x11223344 -> single write of 0xBEEF3344 to mem_address=5; no other write pulses.
4. rsp_ready held low 3 cycles after rsp_valid -> rsp_rdata and rsp_err stable, req_ready=0 throughout. A second request is accepted only in the cycle after the handshake.
5. Word load from addr 0x5:
   - With MISALIGN_TRAP_EN: rsp_err=1, no write_enable, mem_address unchanged.
   - Without it: reads index 1, rsp_err=0.
6. rst_n pulsed low during RD_WAIT of a byte store -> mem_write_enable stays 0, rsp_valid=0, req_ready=1 after release, and the memory word is unchanged.

Source files
------------

// File: rtl/lsu_mem_master.sv
// ---------------------------------------------------------------------------
// lsu_mem_master
//   Load/store initiator between the DSP pipeline and a single-port data
//   memory. Byte/half/word requests arrive over a valid/ready handshake, one
//   at a time. Sub-word stores are done as read-modify-write. Load results
//   are lane-extracted, sign/zero-extended and returned over a valid/ready
//   response channel.
//
//   Build option: define MISALIGN_TRAP_EN to reject misaligned half/word
//   accesses with rsp_err=1 and no memory access. Without it the low
//   address bits that do not select a lane are ignored.
//
//   Parameters
//     ADDR_W : byte address width (mem_address is a word index, same width)
//     RD_LAT : cycles mem_address is held before mem_read_data is sampled (1..4)
//
//   Ports
//     clk, rst_n          : clock, asynchronous active-low reset
//     req_*               : request channel (valid/ready, we, size, signed,
//                           addr, wdata)
//     rsp_*               : response channel (valid/ready, rdata, err)
//     mem_address         : word index driven to memory
//     mem_write_data      : word written to memory
//     mem_write_enable    : single-cycle write strobe
//     mem_read_data       : word read from memory
//     busy                : high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module lsu_mem_master #(
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_write_data,
   output logic              mem_write_enable,
   input  logic [31:0]       mem_read_data,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;

   localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

   state_t      state;
   logic        we_reg;
   logic        signed_reg;
   logic [1:0]  size_reg;
   logic [1:0]  lane_reg;    // addr[1:0] of the accepted request
   logic [15:0] wdata_reg;   // only the sub-word part is needed after accept
   logic [2:0]  lat_cnt;

   logic        req_err;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;
   logic [31:0] merged_word;

   // Requests that must be rejected without touching memory.
   always_comb begin
      req_err = (req_size == 2'b11);
`ifdef MISALIGN_TRAP_EN
      if (req_size == 2'b01 && req_addr[0])
         req_err = 1'b1;
      if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
         req_err = 1'b1;
`endif
   end

   // Load lane extraction and extension (little-endian lanes).
   always_comb begin
      case (lane_reg)
         2'd0:    ld_byte = mem_read_data[7:0];
         2'd1:    ld_byte = mem_read_data[15:8];
         2'd2:    ld_byte = mem_read_data[23:16];
         default: ld_byte = mem_read_data[31:24];
      endcase
      ld_half = lane_reg[1] ? mem_read_data[31:16] : mem_read_data[15:0];
      case (size_reg)
         2'b00:   load_data = {{24{signed_reg & ld_byte[7]}}, ld_byte};
         2'b01:   load_data = {{16{signed_reg & ld_half[15]}}, ld_half};
         default: load_data = mem_read_data;
      endcase
   end

   // Store merge: replace only the addressed byte(s) of the read word.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic       lane_sel;
         logic [7:0] new_byte;

         assign lane_sel = (size_reg == 2'b00) ? (lane_reg == 2'(gi))
                                               : (lane_reg[1] == 1'(gi / 2));
         if ((gi % 2) == 1) begin : g_odd
            // Odd lanes take the high byte of a half store.
            assign new_byte = (size_reg == 2'b01) ? wdata_reg[15:8] : wdata_reg[7:0];
         end else begin : g_even
            assign new_byte = wdata_reg[7:0];
         end
         assign merged_word[8*gi +: 8] = lane_sel ? new_byte : mem_read_data[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         req_ready        <= 1'b1;
         rsp_valid        <= 1'b0;
         rsp_rdata        <= 32'h0;
         rsp_err          <= 1'b0;
         mem_address      <= '0;
         mem_write_data   <= 32'h0;
         mem_write_enable <= 1'b0;
         busy             <= 1'b0;
         lat_cnt          <= 3'd0;
         we_reg           <= 1'b0;
         signed_reg       <= 1'b0;
         size_reg         <= 2'b00;
         lane_reg         <= 2'b00;
         wdata_reg        <= 16'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_reg     <= req_we;
                  size_reg   <= req_size;
                  signed_reg <= req_signed;
                  lane_reg   <= req_addr[1:0];
                  wdata_reg  <= req_wdata[15:0];
                  lat_cnt    <= 3'd0;
                  req_ready  <= 1'b0;
                  busy       <= 1'b1;
                  if (req_err) begin
                     // Rejected: mem_address keeps its previous value.
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= 32'h0;
                     state     <= RESP;
                  end else begin
                     mem_address <= req_addr >> 2;
                     if (req_we && req_size == 2'b10) begin
                        mem_write_data   <= req_wdata;
                        mem_write_enable <= 1'b1;
                        state            <= WR;
                     end else begin
                        state <= RD_WAIT;
                     end
                  end
               end
            end

            RD_WAIT: begin
               if (lat_cnt == LAT_LAST) begin
                  lat_cnt <= 3'd0;
                  if (we_reg) begin
                     mem_write_data   <= merged_word;
                     mem_write_enable <= 1'b1;
                     state            <= WR;
                  end else begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b0;
                     rsp_rdata <= load_data;
                     state     <= RESP;
                  end
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end

            WR: begin
               mem_write_enable <= 1'b0;
               rsp_valid        <= 1'b1;
               rsp_err          <= 1'b0;
               rsp_rdata        <= 32'h0;
               state            <= RESP;
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               mem_write_enable <= 1'b0;
               rsp_valid        <= 1'b0;
               req_ready        <= 1'b1;
               busy             <= 1'b0;
               state            <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_master
//   Directed, table-driven bench for lsu_mem_master with RD_LAT=1 and a
//   small behavioural memory (combinational read, registered write).
//   Expectations follow MISALIGN_TRAP_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_lsu_mem_master;

   localparam int ADDR_W = 32;
   localparam int L      = 1;   // RD_LAT under test

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid, req_ready, req_we, req_signed;
   logic [1:0]        req_size;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid, rsp_ready, rsp_err;
   logic [31:0]       rsp_rdata;
   logic [ADDR_W-1:0] mem_address;
   logic [31:0]       mem_write_data, mem_read_data;
   logic              mem_write_enable, busy;

   always #5 clk = ~clk;

   lsu_mem_master #(.ADDR_W(ADDR_W), .RD_LAT(L)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data),
      .busy(busy)
   );

   // Behavioural memory; the bench preloads words through pre_* so that
   // the array has a single writing process.
   logic [31:0] mem [0:63];
   logic        pre_en = 1'b0;
   logic [5:0]  pre_idx = 6'd0;
   logic [31:0] pre_data = 32'h0;
   logic [5:0]  mem_idx;
   int          wr_pulses = 0;

   assign mem_idx       = 6'(mem_address);
   assign mem_read_data = mem[mem_idx];

   always @(posedge clk) begin
      if (pre_en)
         mem[pre_idx] <= pre_data;
      if (mem_write_enable) begin
         mem[mem_idx] <= mem_write_data;
         wr_pulses    <= wr_pulses + 1;
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [5:0]  pre_idx;
      logic [31:0] pre_word;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_rsp;      // response cycle after accept
      int          exp_wr;       // write cycle after accept, 0 = no write
      logic [31:0] exp_wr_data;
      logic [31:0] exp_maddr;    // mem_address while the response is shown
   } vec_t;

   localparam int NV = 13;
   vec_t vt [NV];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic preload(input logic [5:0] idx, input logic [31:0] word);
      @(negedge clk);
      pre_en   = 1'b1;
      pre_idx  = idx;
      pre_data = word;
      @(posedge clk);
      #1 pre_en = 1'b0;
   endtask

   task automatic drive_req(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wdata);
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      req_valid  = 1'b1;
   endtask

   task automatic run_txn(input int idx, input vec_t v);
      int          k;
      int          wr_n;
      int          wr_cyc;
      logic [31:0] wr_data;
      logic [31:0] wr_addr;
      preload(v.pre_idx, v.pre_word);
      @(negedge clk);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      drive_req(v.we, v.size, v.sgn, v.addr, v.wdata);
      @(posedge clk);
      #1 req_valid = 1'b0;
      k = 0; wr_n = 0; wr_cyc = 0; wr_data = 32'h0; wr_addr = 32'h0;
      do begin
         @(negedge clk);
         k++;
         if (mem_write_enable) begin
            wr_n++;
            wr_cyc  = k;
            wr_data = mem_write_data;
            wr_addr = mem_address;
         end
         if (!rsp_valid)
            check("req_ready_while_busy", 32'(req_ready), 32'd0);
      end while (!rsp_valid && k < 20);
      check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
      check("rsp_cycle", 32'(k), 32'(v.exp_rsp));
      check("rsp_rdata", rsp_rdata, v.exp_rdata);
      check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
      check("req_ready_in_resp", 32'(req_ready), 32'd0);
      check("write_count", 32'(wr_n), (v.exp_wr != 0) ? 32'd1 : 32'd0);
      check("mem_address_at_rsp", mem_address, v.exp_maddr);
      if (v.exp_wr != 0) begin
         check("write_cycle", 32'(wr_cyc), 32'(v.exp_wr));
         check("write_data", wr_data, v.exp_wr_data);
         check("write_addr", wr_addr, v.exp_maddr);
      end
      $display("txn %0d we=%0b size=%0d sgn=%0b addr=%h wdata=%h -> rdata=%h err=%0b cyc=%0d writes=%0d",
               idx, v.we, v.size, v.sgn, v.addr, v.wdata, rsp_rdata, rsp_err, k, wr_n);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          k;
      int          wr_base;
      logic [31:0] held_rdata;

      //        we    size   sgn   addr        wdata         pi     pre_word      exp_rdata     err   rsp  wr   wr_data       maddr
      vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h0,      32'hA5A5A5A5, 6'd0,  32'h00000000, 32'h00000000, 1'b0, 2,   1,   32'hA5A5A5A5, 32'd0};
      vt[1]  = '{1'b0, 2'b00, 1'b1, 32'h6,      32'h0,        6'd1,  32'h12845678, 32'hFFFFFF84, 1'b0, L+1, 0,   32'h0,        32'd1};
      vt[2]  = '{1'b0, 2'b00, 1'b0, 32'h6,      32'h0,        6'd1,  32'h12845678, 32'h00000084, 1'b0, L+1, 0,   32'h0,        32'd1};
      vt[3]  = '{1'b1, 2'b01, 1'b0, 32'h16,     32'h0000BEEF, 6'd5,  32'h11223344, 32'h00000000, 1'b0, L+2, L+1, 32'hBEEF3344, 32'd5};
      vt[4]  = '{1'b0, 2'b11, 1'b0, 32'h8,      32'h0,        6'd2,  32'h12345678, 32'h00000000, 1'b1, 1,   0,   32'h0,        32'd5};
      vt[5]  = '{1'b1, 2'b11, 1'b0, 32'hC,      32'hFFFFFFFF, 6'd3,  32'h00000055, 32'h00000000, 1'b1, 1,   0,   32'h0,        32'd5};
`ifdef MISALIGN_TRAP_EN
      vt[6]  = '{1'b0, 2'b10, 1'b0, 32'h5,      32'h0,        6'd1,  32'hCAFEF00D, 32'h00000000, 1'b1, 1,   0,   32'h0,        32'd5};
`else
      vt[6]  = '{1'b0, 2'b10, 1'b0, 32'h5,      32'h0,        6'd1,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0, L+1, 0,   32'h0,        32'd1};
`endif
      vt[7]  = '{1'b1, 2'b00, 1'b0, 32'h9,      32'h0000007E, 6'd2,  32'hAABBCCDD, 32'h00000000, 1'b0, L+2, L+1, 32'hAABB7EDD, 32'd2};
      vt[8]  = '{1'b0, 2'b01, 1'b1, 32'hE,      32'h0,        6'd3,  32'h9ABC1234, 32'hFFFF9ABC, 1'b0, L+1, 0,   32'h0,        32'd3};
      vt[9]  = '{1'b0, 2'b01, 1'b1, 32'hC,      32'h0,        6'd3,  32'h9ABC1234, 32'h00001234, 1'b0, L+1, 0,   32'h0,        32'd3};
      vt[10] = '{1'b0, 2'b10, 1'b1, 32'h10,     32'h0,        6'd4,  32'h80000001, 32'h80000001, 1'b0, L+1, 0,   32'h0,        32'd4};
`ifdef MISALIGN_TRAP_EN
      vt[11] = '{1'b1, 2'b01, 1'b0, 32'h1,      32'h00001234, 6'd0,  32'hFFFFFFFF, 32'h00000000, 1'b1, 1,   0,   32'h0,        32'd4};
`else
      vt[11] = '{1'b1, 2'b01, 1'b0, 32'h1,      32'h00001234, 6'd0,  32'hFFFFFFFF, 32'h00000000, 1'b0, L+2, L+1, 32'hFFFF1234, 32'd0};
`endif
      vt[12] = '{1'b0, 2'b00, 1'b1, 32'h3,      32'h0,        6'd0,  32'h7F000000, 32'h0000007F, 1'b0, L+1, 0,   32'h0,        32'd0};

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = 32'h0;
      rsp_ready  = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_mem_address", mem_address, 32'h0);
      check("rst_mem_write_data", mem_write_data, 32'h0);
      check("rst_mem_write_enable", 32'(mem_write_enable), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < NV; i++)
         run_txn(i, vt[i]);

      // Response back-pressure, and a request parked during RESP
      preload(6'd1, 32'h12845678);
      preload(6'd4, 32'h80000001);
      @(negedge clk);
      drive_req(1'b0, 2'b00, 1'b0, 32'h6, 32'h0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!rsp_valid && k < 20);
      check("bp_rsp_valid_seen", 32'(rsp_valid), 32'd1);
      held_rdata = rsp_rdata;
      check("bp_rdata", held_rdata, 32'h00000084);
      drive_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("bp_hold_valid", 32'(rsp_valid), 32'd1);
         check("bp_hold_rdata", rsp_rdata, 32'h00000084);
         check("bp_hold_err", 32'(rsp_err), 32'd0);
         check("bp_hold_req_ready", 32'(req_ready), 32'd0);
      end
      $display("txn bp1 load byte addr=00000006 -> rdata=%h held 3 cycles", rsp_rdata);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_after_hs_req_ready", 32'(req_ready), 32'd1);
      check("bp_after_hs_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!rsp_valid && k < 20);
      check("bp2_rsp_valid_seen", 32'(rsp_valid), 32'd1);
      check("bp2_rsp_cycle", 32'(k), 32'(L + 1));
      check("bp2_rdata", rsp_rdata, 32'h80000001);
      $display("txn bp2 load word addr=00000010 -> rdata=%h cyc=%0d", rsp_rdata, k);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;

      // Reset asserted while a byte store is in RD_WAIT
      preload(6'd2, 32'hAABBCCDD);
      wr_base = wr_pulses;
      @(negedge clk);
      drive_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h00000011);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rstmid_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rstmid_req_ready", 32'(req_ready), 32'd1);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_we", 32'(mem_write_enable), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("rstmid_post_we", 32'(mem_write_enable), 32'd0);
         check("rstmid_post_rsp_valid", 32'(rsp_valid), 32'd0);
         check("rstmid_post_req_ready", 32'(req_ready), 32'd1);
      end
      check("rstmid_write_pulses", 32'(wr_pulses - wr_base), 32'd0);
      check("rstmid_mem_word", mem[2], 32'hAABBCCDD);
      $display("txn rst byte store addr=00000009 aborted -> mem[2]=%h writes=%0d",
               mem[2], wr_pulses - wr_base);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
